// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, RDW mode constants and byte merge for the dual-port RAM
package ram_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] wdata,
                                            input logic       be);
    return be ? wdata : old_byte;
  endfunction

endpackage

// File: rtl/dual_port_sync_ram_be_if.sv
// rtl/dual_port_sync_ram_be_if.sv - one request/response port of the dual-port RAM
interface dual_port_sync_ram_be_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NBYTES-1:0]     be;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;

  modport master (output req, we, addr, wdata, be, input ready, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, be, output ready, rdata, rvalid);

endinterface

// File: rtl/ram_read_pipe.sv
// rtl/ram_read_pipe.sv - read data/valid delay line; data stages only advance with valid so rdata holds
module ram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [READ_LATENCY-1:0] v_q;
  logic [DATA_WIDTH-1:0]   d_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) d_q[k] <= '0;
    end else begin
      v_q[0] <= in_valid;
      if (in_valid) d_q[0] <= in_data;
      for (int k = 1; k < READ_LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign rvalid = v_q[READ_LATENCY-1];
  assign rdata  = d_q[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_sync_ram_be.sv
// rtl/dual_port_sync_ram_be.sv - two-port byte-enabled synchronous RAM with post-reset clear sweep
module dual_port_sync_ram_be
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  dual_port_sync_ram_be_if.slave    a,
  dual_port_sync_ram_be_if.slave    b,
  output logic                      init_done
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_word,
                                                       input logic [DATA_WIDTH-1:0] wdata,
                                                       input logic [NBYTES-1:0]     be);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = merge_byte(old_word[8*i +: 8], wdata[8*i +: 8], be[i]);
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q;
  logic                  clear_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_en = 1'b0;
    if (state_q == CLEAR) begin
      clear_en = 1'b1;
      cnt_d    = cnt_q + 1'b1;
      if (&cnt_q) state_d = RUN;
    end
  end

  logic                  a_wr, b_wr, a_rd, b_rd, same_addr, collide;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, ab_new, a_rd_word, b_rd_word;

  assign a_wr      = a.req & a.we & ready_q;
  assign b_wr      = b.req & b.we & ready_q;
  assign a_rd      = a.req & ~a.we & ready_q;
  assign b_rd      = b.req & ~b.we & ready_q;
  assign same_addr = (a.addr == b.addr);
  assign collide   = a_wr & b_wr & same_addr;

  assign a_old  = mem[a.addr];
  assign b_old  = mem[b.addr];
  assign a_new  = merge_word(a_old, a.wdata, a.be);
  assign b_new  = merge_word(b_old, b.wdata, b.be);
  // On a same-address double write, A's bytes are laid over B's merge.
  assign ab_new = merge_word(b_new, a.wdata, a.be);

  // A reading port is never writing, so the other port's merge is the post-write word.
  assign a_rd_word = (RDW_MODE == RDW_WRITE_FIRST && b_wr && same_addr) ? b_new : a_old;
  assign b_rd_word = (RDW_MODE == RDW_WRITE_FIRST && a_wr && same_addr) ? a_new : b_old;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_en) begin
        mem[cnt_q] <= '0;
      end else begin
        if (a_wr) mem[a.addr] <= collide ? ab_new : a_new;
        if (b_wr && !collide) mem[b.addr] <= b_new;
      end
    end
  end

  ram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
    .clk(clk), .rst(rst), .in_valid(a_rd), .in_data(a_rd_word), .rdata(a.rdata), .rvalid(a.rvalid)
  );

  ram_read_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
    .clk(clk), .rst(rst), .in_valid(b_rd), .in_data(b_rd_word), .rdata(b.rdata), .rvalid(b.rvalid)
  );

  assign a.ready   = ready_q;
  assign b.ready   = ready_q;
  assign init_done = ready_q;

endmodule

// File: tb/tb_dual_port_sync_ram_be.sv
// tb/tb_dual_port_sync_ram_be.sv - directed bench: read-first/latency-1 and write-first/latency-2 instances
module tb_dual_port_sync_ram_be;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_rf, done_wf;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dual_port_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ra ();
  dual_port_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) rb ();
  dual_port_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) wa ();
  dual_port_sync_ram_be_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) wb ();

  dual_port_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut_rf (.clk(clk), .rst(rst), .a(ra), .b(rb), .init_done(done_rf));

  dual_port_sync_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
    dut_wf (.clk(clk), .rst(rst), .a(wa), .b(wb), .init_done(done_wf));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic req, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    ra.req = req; ra.we = we; ra.addr = addr; ra.wdata = wdata; ra.be = be;
    wa.req = req; wa.we = we; wa.addr = addr; wa.wdata = wdata; wa.be = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    rb.req = req; rb.we = we; rb.addr = addr; rb.wdata = wdata; rb.be = be;
    wb.req = req; wb.we = we; wb.addr = addr; wb.wdata = wdata; wb.be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic write_a(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    set_a(1'b1, 1'b1, addr, data, be);
    tick();
    idle();
  endtask

  task automatic read_a(input logic [3:0] addr, output logic [31:0] d_rf, output logic [31:0] d_wf, output bit ok);
    set_a(1'b1, 1'b0, addr, 32'h0, 4'h0);
    tick();
    idle();
    ok   = (ra.rvalid === 1'b1) && (wa.rvalid === 1'b0);
    d_rf = ra.rdata;
    tick();
    ok   = ok && (ra.rvalid === 1'b0) && (wa.rvalid === 1'b1);
    d_wf = wa.rdata;
  endtask

  task automatic check_read_a(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d_rf, d_wf;
    bit ok;
    read_a(addr, d_rf, d_wf, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL %s_rvalid_timing: got %0b want 1", tag, ok); end
    n_cmp++;
    if (d_rf !== exp) begin n_err++; $display("FAIL %s_rf: got %h want %h", tag, d_rf, exp); end
    n_cmp++;
    if (d_wf !== exp) begin n_err++; $display("FAIL %s_wf: got %h want %h", tag, d_wf, exp); end
  endtask

  task automatic wait_sweep(input string tag);
    int low = 0;
    while (ra.ready === 1'b0 && low < 40) begin
      low++;
      tick();
    end
    n_cmp++;
    if (low !== 16) begin n_err++; $display("FAIL %s_sweep_len: got %0d want 16", tag, low); end
    n_cmp++;
    if ({ra.ready, rb.ready, wa.ready, wb.ready, done_rf, done_wf} !== 6'b111111) begin
      n_err++;
      $display("FAIL %s_ready_after_sweep: got %b want 111111", tag,
               {ra.ready, rb.ready, wa.ready, wb.ready, done_rf, done_wf});
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({ra.ready, rb.ready, wa.ready, wb.ready, done_rf, done_wf} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 000000", {ra.ready, rb.ready, wa.ready, wb.ready, done_rf, done_wf});
    end
    n_cmp++;
    if ({ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_rvalid: got %b want 0000", {ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid});
    end
    n_cmp++;
    if ((ra.rdata | rb.rdata | wa.rdata | wb.rdata) !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h %h %h %h want 0", ra.rdata, rb.rdata, wa.rdata, wb.rdata);
    end
    rst = 1'b0;
    wait_sweep("reset");
  endtask

  task automatic test_clear_sweep();
    write_a(4'd3, 32'hFFFF_FFFF, 4'hF);
    check_read_a("preload", 4'd3, 32'hFFFF_FFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_sweep("clear");
    check_read_a("cleared", 4'd3, 32'h0000_0000);
  endtask

  task automatic test_byte_enable();
    write_a(4'd5, 32'hDEAD_BEEF, 4'hF);
    write_a(4'd5, 32'h1122_3344, 4'b0101);
    check_read_a("be_partial", 4'd5, 32'hDE22_BE44);
    write_a(4'd5, 32'hFFFF_FFFF, 4'b0000);
    check_read_a("be_zero", 4'd5, 32'hDE22_BE44);
  endtask

  task automatic test_collision();
    set_a(1'b1, 1'b1, 4'd7, 32'hAAAA_AAAA, 4'b0011);
    set_b(1'b1, 1'b1, 4'd7, 32'hBBBB_BBBB, 4'b0110);
    tick();
    idle();
    check_read_a("ww_collide", 4'd7, 32'h00BB_AAAA);
  endtask

  task automatic test_rdw();
    write_a(4'd9, 32'h1, 4'hF);
    set_a(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    set_b(1'b1, 1'b1, 4'd9, 32'h2, 4'hF);
    tick();
    set_b(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    n_cmp++;
    if (ra.rvalid !== 1'b1 || ra.rdata !== 32'h1) begin
      n_err++; $display("FAIL rdw_same_cycle_rf: got v=%b d=%h want v=1 d=00000001", ra.rvalid, ra.rdata);
    end
    tick();
    idle();
    n_cmp++;
    if (ra.rvalid !== 1'b1 || ra.rdata !== 32'h2) begin
      n_err++; $display("FAIL rdw_next_cycle_rf: got v=%b d=%h want v=1 d=00000002", ra.rvalid, ra.rdata);
    end
    n_cmp++;
    if (wa.rvalid !== 1'b1 || wa.rdata !== 32'h2) begin
      n_err++; $display("FAIL rdw_same_cycle_wf: got v=%b d=%h want v=1 d=00000002", wa.rvalid, wa.rdata);
    end
    tick();
    n_cmp++;
    if (wa.rvalid !== 1'b1 || wa.rdata !== 32'h2) begin
      n_err++; $display("FAIL rdw_next_cycle_wf: got v=%b d=%h want v=1 d=00000002", wa.rvalid, wa.rdata);
    end
    set_a(1'b1, 1'b1, 4'd10, 32'h0000_0055, 4'b0001);
    set_b(1'b1, 1'b0, 4'd10, 32'h0, 4'h0);
    tick();
    idle();
    n_cmp++;
    if (rb.rvalid !== 1'b1 || rb.rdata !== 32'h0) begin
      n_err++; $display("FAIL rdw_portb_rf: got v=%b d=%h want v=1 d=00000000", rb.rvalid, rb.rdata);
    end
    tick();
    n_cmp++;
    if (wb.rvalid !== 1'b1 || wb.rdata !== 32'h55) begin
      n_err++; $display("FAIL rdw_portb_wf: got v=%b d=%h want v=1 d=00000055", wb.rvalid, wb.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      set_b(1'b1, 1'b1, 4'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
      tick();
    end
    idle();
    for (int t = 0; t < 20; t++) begin
      if (t < 16) set_a(1'b1, 1'b0, 4'(t), 32'h0, 4'h0);
      else        set_a(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
      tick();
      exp = 32'hC0DE_0000 + 32'(t);
      n_cmp++;
      if (ra.rvalid !== (t < 16) || ((t < 16) && ra.rdata !== exp)) begin
        n_err++; $display("FAIL b2b_rf_t%0d: got v=%b d=%h want v=%0d d=%h", t, ra.rvalid, ra.rdata, (t < 16), exp);
      end
      exp = 32'hC0DE_0000 + 32'(t) - 32'h1;
      n_cmp++;
      if (wa.rvalid !== (t >= 1 && t <= 16) || ((t >= 1 && t <= 16) && wa.rdata !== exp)) begin
        n_err++; $display("FAIL b2b_wf_t%0d: got v=%b d=%h want v=%0d d=%h", t, wa.rvalid, wa.rdata, (t >= 1 && t <= 16), exp);
      end
    end
  endtask

  task automatic test_reset_flush();
    int  low = 0;
    bit  seen = 1'b0;
    set_a(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid} !== 4'b0) begin
      n_err++; $display("FAIL flush_rvalid: got %b want 0000", {ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid});
    end
    n_cmp++;
    if ((ra.rdata | rb.rdata | wa.rdata | wb.rdata) !== 32'h0) begin
      n_err++; $display("FAIL flush_rdata: got %h %h %h %h want 0", ra.rdata, rb.rdata, wa.rdata, wb.rdata);
    end
    rst = 1'b0;
    set_b(1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF);
    while (ra.ready === 1'b0 && low < 40) begin
      if ({ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid} !== 4'b0) seen = 1'b1;
      low++;
      tick();
    end
    if ({ra.rvalid, rb.rvalid, wa.rvalid, wb.rvalid} !== 4'b0) seen = 1'b1;
    idle();
    n_cmp++;
    if (low !== 16) begin n_err++; $display("FAIL flush_sweep_len: got %0d want 16", low); end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL flush_stray_rvalid: got %0b want 0", seen); end
    check_read_a("flush_ignored_write", 4'd2, 32'h0);
    check_read_a("flush_cleared", 4'd5, 32'h0);
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_byte_enable();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
